alu_writeback_stage: RTL and testbench
======================================

ALU_WRITEBACK_STAGE -- requirements
Module: alu_writeback_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the result/register data width.
REQ-002 The block SHALL have parameter NREGS, default 4, giving the register count; the address width is clog2(NREGS).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  upstream result presented.
REQ-006 in_ready  output  1  block can accept a result this cycle.
REQ-007 in_result  input  WIDTH  arithmetic result.
REQ-008 in_carry  input  1  carry/borrow from the arithmetic stage.
REQ-009 in_overflow  input  1  signed overflow from the arithmetic stage.
REQ-010 in_dest  input  clog2(NREGS)  destination register index.
REQ-011 in_wen  input  1  write result to the register file.
REQ-012 in_flag_en  input  1  update flags on commit.
REQ-013 stall  input  1  downstream hold; blocks commit.
REQ-014 clr_sticky  input  1  clear the sticky overflow bit.
REQ-015 rd_addr_a/rd_addr_b  input  clog2(NREGS)  read addresses.
REQ-016 rd_data_a/rd_data_b  output  WIDTH  read data.
REQ-017 flags  output  4  {Z,N,C,V}, registered.
REQ-018 sticky_v  output  1  overflow seen since last clear.
REQ-019 wb_valid  output  1  one-cycle pulse on commit.
REQ-020 wb_dest  output  clog2(NREGS)  destination of the last commit.
REQ-021 wb_count  output  8  saturating commit counter.

Function
REQ-022 The block SHALL hold one stage entry; in_ready = !stage_valid || !stall, computed combinationally.
REQ-023 Capture: when in_valid && in_ready, the block SHALL latch all in_* fields into the stage and set stage_valid.
REQ-024 Commit: when stage_valid && !stall, the block SHALL commit the entry on that edge; the input-to-commit latency is therefore 2 edges.
REQ-025 Simultaneous commit and capture SHALL be allowed, giving throughput of one result per cycle with no bubble.
REQ-026 Commit SHALL clear stage_valid unless a new capture occurs on the same edge.
REQ-027 On commit with in_wen=1, regfile[in_dest] SHALL be set to the result; with in_wen=0, no register changes.
REQ-028 On commit with in_flag_en=1: Z = (result==0), N = result[WIDTH-1], C = carry, V = overflow; with in_flag_en=0, flags SHALL hold.
REQ-029 sticky_v SHALL be set on any commit with overflow=1 and in_flag_en=1; clr_sticky SHALL clear it; a set on the same edge as a clear SHALL win.
REQ-030 wb_valid SHALL be 1 for exactly the cycle after each commit edge, and wb_dest SHALL update on commit.
REQ-031 wb_count SHALL increment on each commit and saturate at 255.
REQ-032 Reads SHALL be combinational; when a commit with in_wen=1 is in progress to the same address, the read SHALL return the committing data (bypass).
REQ-033 While stall=1 with stage_valid=1, the stage contents SHALL stay unchanged and in_ready SHALL be 0.
REQ-034 Any out-of-range in_dest (NREGS not a power of 2) SHALL suppress the register write only; flags still update.

Reset
REQ-035 When rst=1, the block SHALL clear stage_valid, all registers, flags, sticky_v, wb_valid, wb_dest and wb_count to 0 on the next edge.
REQ-036 When rst=1, an entry in flight SHALL be discarded without commit; in_ready SHALL read 1 in the first cycle after reset.
REQ-037 rst SHALL take priority over capture, commit and clr_sticky.

Structure
REQ-038 The shared package alu_wb_pkg SHALL hold the flag bit indices (Z=3, N=2, C=1, V=0), WB_COUNT_W=8 and the default NREGS.
REQ-039 The register file with two read ports, write port and bypass SHALL be the sub-module alu_regfile.

Verification
REQ-040 Reset, then write 4'h0 to r1 with carry=1 and flag_en=1 -> after 2 edges flags=4'b1010, wb_valid pulses, r1=0.
REQ-041 Write 4'h8 with overflow=1, then write 4'h3 with overflow=0 -> flags end at 4'b0000 and sticky_v stays 1; assert clr_sticky -> sticky_v=0.
REQ-042 Hold stall=1 for 3 cycles with an entry held and in_valid=1 -> in_ready=0, no commit, stage unchanged; release stall -> back-to-back commits with no bubble.
REQ-043 Commit 5 to r2 while rd_addr_a=2 -> rd_data_a=5 in the same cycle (bypass).
REQ-044 Run 300 commits -> wb_count=255.
REQ-045 Assert rst while an entry is held -> no write, all outputs 0, in_ready=1.

Source files
------------

// File: rtl/alu_writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : alu_wb_pkg
//  Purpose   : Shared constants, flag layout and helpers for the ALU
//              writeback stage and its register file.
//  Revision  : 1.0  initial release
// ============================================================================
package alu_wb_pkg;

  // Bit positions of the condition flags inside the 4-bit flags word.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int FLAGS_W = 4;

  // Width of the saturating commit counter.
  localparam int WB_COUNT_W = 8;

  // Register count used when the instantiating level does not override it.
  localparam int DEFAULT_NREGS = 4;

  typedef logic [FLAGS_W-1:0] flags_t;

  // Address width for a register file of n entries; a single-entry file
  // still gets one address bit so vectors never collapse to zero width.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Assemble the flags word from its individual conditions.
  function automatic flags_t pack_flags(input logic z, input logic n,
                                        input logic c, input logic v);
    flags_t f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_writeback_stage_if.sv
`default_nettype none
// ============================================================================
//  Interface : alu_writeback_stage_if
//  Purpose   : Upstream result handshake into the writeback stage: the
//              arithmetic result, its side flags and the write controls.
//  Revision  : 1.0  initial release
// ============================================================================
interface alu_writeback_stage_if
  import alu_wb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREGS = DEFAULT_NREGS
);

  localparam int AW = addr_width(NREGS);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             in_overflow;
  logic [AW-1:0]    in_dest;
  logic             in_wen;
  logic             in_flag_en;

  // Arithmetic stage side: presents results, observes ready.
  modport master (
    output in_valid, in_result, in_carry, in_overflow, in_dest, in_wen, in_flag_en,
    input  in_ready
  );

  // Writeback stage side: accepts results, drives ready.
  modport slave (
    input  in_valid, in_result, in_carry, in_overflow, in_dest, in_wen, in_flag_en,
    output in_ready
  );

endinterface
`default_nettype wire

// File: rtl/alu_writeback_stage_regfile.sv
`default_nettype none
// ============================================================================
//  Module    : alu_regfile
//  Purpose   : NREGS x WIDTH register file, one write port, two combinational
//              read ports with same-cycle write-to-read bypass.
//  Revision  : 1.0  initial release
// ============================================================================
module alu_regfile
  import alu_wb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREGS = DEFAULT_NREGS,
  parameter int AW    = addr_width(NREGS)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_we,
  input  wire logic [AW-1:0]    i_waddr,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic [AW-1:0]    i_raddr_a,
  input  wire logic [AW-1:0]    i_raddr_b,
  output logic      [WIDTH-1:0] o_rdata_a,
  output logic      [WIDTH-1:0] o_rdata_b
);

  logic [WIDTH-1:0] r_regs [NREGS];

  // Addresses beyond NREGS-1 exist only when NREGS is not a power of two;
  // writes to them are dropped and reads of them return zero.
  logic w_waddr_ok;
  logic w_raddr_a_ok;
  logic w_raddr_b_ok;
  logic w_write;

  assign w_waddr_ok   = (int'(i_waddr)   < NREGS);
  assign w_raddr_a_ok = (int'(i_raddr_a) < NREGS);
  assign w_raddr_b_ok = (int'(i_raddr_b) < NREGS);
  assign w_write      = i_we && w_waddr_ok;

  // Storage: cleared on reset, written on a valid in-range write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports: a write landing on this edge is forwarded to matching reads.
  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    if (w_write && (i_raddr_a == i_waddr)) begin
      o_rdata_a = i_wdata;
    end else if (w_raddr_a_ok) begin
      o_rdata_a = r_regs[i_raddr_a];
    end
    if (w_write && (i_raddr_b == i_waddr)) begin
      o_rdata_b = i_wdata;
    end else if (w_raddr_b_ok) begin
      o_rdata_b = r_regs[i_raddr_b];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module    : alu_writeback_stage
//  Purpose   : Single-entry writeback stage behind an ALU. Captures a result,
//              commits it to the register file and flags when downstream is
//              not stalled, tracks sticky overflow and counts commits.
//  Revision  : 1.0  initial release
// ============================================================================
module alu_writeback_stage
  import alu_wb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREGS = DEFAULT_NREGS
) (
  input  wire logic                            clk,
  input  wire logic                            rst,
  alu_writeback_stage_if.slave                 up,
  input  wire logic                            stall,
  input  wire logic                            clr_sticky,
  input  wire logic [addr_width(NREGS)-1:0]    rd_addr_a,
  input  wire logic [addr_width(NREGS)-1:0]    rd_addr_b,
  output logic      [WIDTH-1:0]                rd_data_a,
  output logic      [WIDTH-1:0]                rd_data_b,
  output logic      [FLAGS_W-1:0]              flags,
  output logic                                 sticky_v,
  output logic                                 wb_valid,
  output logic      [addr_width(NREGS)-1:0]    wb_dest,
  output logic      [WB_COUNT_W-1:0]           wb_count
);

  localparam int AW = addr_width(NREGS);

  // Stage entry.
  logic             r_stage_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic [AW-1:0]    r_dest;
  logic             r_wen;
  logic             r_flag_en;

  // Architectural outputs.
  flags_t                r_flags;
  logic                  r_sticky_v;
  logic                  r_wb_valid;
  logic [AW-1:0]         r_wb_dest;
  logic [WB_COUNT_W-1:0] r_wb_count;

  logic w_in_ready;
  logic w_capture;
  logic w_commit;
  logic w_rf_we;

  // The slot is free when empty or when its occupant leaves on this edge,
  // which lets a new result follow directly behind a committing one.
  assign w_in_ready = !r_stage_valid || !stall;
  assign w_capture  = up.in_valid && w_in_ready;
  assign w_commit   = r_stage_valid && !stall;
  assign w_rf_we    = w_commit && r_wen;

  assign up.in_ready = w_in_ready;

  // Stage slot: load on capture, empty on a commit with nothing arriving.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_valid <= 1'b0;
      r_result      <= '0;
      r_carry       <= 1'b0;
      r_overflow    <= 1'b0;
      r_dest        <= '0;
      r_wen         <= 1'b0;
      r_flag_en     <= 1'b0;
    end else if (w_capture) begin
      r_stage_valid <= 1'b1;
      r_result      <= up.in_result;
      r_carry       <= up.in_carry;
      r_overflow    <= up.in_overflow;
      r_dest        <= up.in_dest;
      r_wen         <= up.in_wen;
      r_flag_en     <= up.in_flag_en;
    end else if (w_commit) begin
      r_stage_valid <= 1'b0;
    end
  end

  // Condition flags: refreshed only by commits that carry flag_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_commit && r_flag_en) begin
      r_flags <= pack_flags(r_result == '0, r_result[WIDTH-1], r_carry, r_overflow);
    end
  end

  // Sticky overflow: a new overflow outranks a clear on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky_v <= 1'b0;
    end else if (w_commit && r_flag_en && r_overflow) begin
      r_sticky_v <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky_v <= 1'b0;
    end
  end

  // Commit reporting: one-cycle pulse, last destination, saturating count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_dest  <= '0;
      r_wb_count <= '0;
    end else begin
      r_wb_valid <= w_commit;
      if (w_commit) begin
        r_wb_dest <= r_dest;
        if (r_wb_count != '1) begin
          r_wb_count <= r_wb_count + 1'b1;
        end
      end
    end
  end

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_rf_we),
    .i_waddr   (r_dest),
    .i_wdata   (r_result),
    .i_raddr_a (rd_addr_a),
    .i_raddr_b (rd_addr_b),
    .o_rdata_a (rd_data_a),
    .o_rdata_b (rd_data_b)
  );

  assign flags    = r_flags;
  assign sticky_v = r_sticky_v;
  assign wb_valid = r_wb_valid;
  assign wb_dest  = r_wb_dest;
  assign wb_count = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module    : tb_alu_writeback_stage
//  Purpose   : Self-checking bench for alu_writeback_stage: directed scenarios
//              plus randomized traffic against a behavioural model.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_alu_writeback_stage;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          clr_sticky;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [W-1:0]  rd_data_a;
  logic [W-1:0]  rd_data_b;
  logic [3:0]    flags;
  logic          sticky_v;
  logic          wb_valid;
  logic [AW-1:0] wb_dest;
  logic [7:0]    wb_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_writeback_stage_if #(.WIDTH(W), .NREGS(N)) bus ();

  alu_writeback_stage #(.WIDTH(W), .NREGS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .up         (bus.slave),
    .stall      (stall),
    .clr_sticky (clr_sticky),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .flags      (flags),
    .sticky_v   (sticky_v),
    .wb_valid   (wb_valid),
    .wb_dest    (wb_dest),
    .wb_count   (wb_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: one pending result, a register array and outputs.
  bit         m_valid;
  logic [W-1:0] m_res;
  bit         m_c, m_v, m_wen, m_fen;
  int         m_dest;
  int         m_regs [N];
  logic [3:0] m_flags;
  bit         m_sticky, m_wbv;
  int         m_wbd, m_cnt;

  function automatic logic [W-1:0] exp_rd(input int a);
    if (m_valid && !stall && m_wen && m_dest == a && m_dest < N) return m_res;
    return m_regs[a][W-1:0];
  endfunction

  // Advance the model by the upcoming edge, then move to 1 ns after it.
  task automatic cycle();
    bit commit, cap;
    if (rst) begin
      m_valid = 0; m_flags = 4'h0; m_sticky = 0; m_wbv = 0; m_wbd = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) m_regs[i] = 0;
    end else begin
      commit = m_valid && !stall;
      cap    = bus.in_valid && (!m_valid || !stall);
      if (commit) begin
        if (m_wen && m_dest < N) m_regs[m_dest] = int'(m_res);
        if (m_fen) m_flags = {m_res == 0, m_res[W-1], m_c, m_v};
        if (m_cnt < 255) m_cnt++;
        m_wbd = m_dest;
      end
      if (commit && m_fen && m_v) m_sticky = 1;
      else if (clr_sticky)        m_sticky = 0;
      m_wbv = commit;
      if (cap) begin
        m_valid = 1; m_res = bus.in_result; m_c = bus.in_carry; m_v = bus.in_overflow;
        m_dest = int'(bus.in_dest); m_wen = bus.in_wen; m_fen = bus.in_flag_en;
      end else if (commit) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] res, input int dest, input bit c,
                      input bit v, input bit wen, input bit fen);
    bus.in_valid = 1'b1; bus.in_result = res; bus.in_dest = AW'(dest);
    bus.in_carry = c; bus.in_overflow = v; bus.in_wen = wen; bus.in_flag_en = fen;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle(); stall = 0; clr_sticky = 0; rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got=%b want=0000", flags); end
    n_checks++; if (sticky_v !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got=%b want=0", sticky_v); end
    n_checks++; if (wb_valid !== 1'b0 || wb_dest !== '0) begin n_fail++; $display("FAIL reset_wb got=%b/%0d want=0/0", wb_valid, wb_dest); end
    n_checks++; if (wb_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", wb_count); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", bus.in_ready); end
    for (int a = 0; a < N; a++) begin
      rd_addr_a = AW'(a); rd_addr_b = AW'(N - 1 - a); #1;
      n_checks++; if (rd_data_a !== '0 || rd_data_b !== '0) begin n_fail++; $display("FAIL reset_reg%0d got=%h/%h want=0/0", a, rd_data_a, rd_data_b); end
    end
  endtask

  task automatic test_zero_flags();
    do_reset();
    rd_addr_a = 1;
    send(4'h0, 1, 1, 0, 1, 1);
    cycle();
    idle();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL zero_early_wb got=%b want=0", wb_valid); end
    cycle();
    n_checks++; if (flags !== 4'b1010) begin n_fail++; $display("FAIL zero_flags got=%b want=1010", flags); end
    n_checks++; if (wb_valid !== 1'b1 || wb_dest !== 2'd1) begin n_fail++; $display("FAIL zero_wb got=%b/%0d want=1/1", wb_valid, wb_dest); end
    n_checks++; if (rd_data_a !== 4'h0 || wb_count !== 8'd1) begin n_fail++; $display("FAIL zero_r1_count got=%h/%0d want=0/1", rd_data_a, wb_count); end
    cycle();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL zero_pulse_width got=%b want=0", wb_valid); end
  endtask

  task automatic test_sticky();
    do_reset();
    send(4'h8, 0, 0, 1, 1, 1);
    cycle();
    send(4'h3, 1, 0, 0, 1, 1);
    cycle();
    n_checks++; if (flags !== 4'b0101 || sticky_v !== 1'b1) begin n_fail++; $display("FAIL sticky_first got=%b/%b want=0101/1", flags, sticky_v); end
    idle();
    cycle();
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL sticky_flags got=%b want=0000", flags); end
    n_checks++; if (sticky_v !== 1'b1) begin n_fail++; $display("FAIL sticky_hold got=%b want=1", sticky_v); end
    clr_sticky = 1;
    cycle();
    clr_sticky = 0;
    n_checks++; if (sticky_v !== 1'b0) begin n_fail++; $display("FAIL sticky_clear got=%b want=0", sticky_v); end
    send(4'h9, 2, 1, 1, 0, 1);
    cycle();
    idle(); clr_sticky = 1;
    cycle();
    clr_sticky = 0;
    n_checks++; if (sticky_v !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins got=%b want=1", sticky_v); end
    n_checks++; if (flags !== 4'b0111) begin n_fail++; $display("FAIL sticky_flags2 got=%b want=0111", flags); end
  endtask

  task automatic test_stall();
    logic [7:0] cnt0;
    do_reset();
    rd_addr_a = 0; rd_addr_b = 1;
    send(4'h6, 0, 0, 0, 1, 1);
    cycle();
    send(4'h9, 1, 1, 0, 1, 1);
    stall = 1;
    cnt0 = wb_count;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got=%b want=0", k, bus.in_ready); end
      n_checks++; if (rd_data_a !== 4'h0) begin n_fail++; $display("FAIL stall_no_bypass[%0d] got=%h want=0", k, rd_data_a); end
      cycle();
      n_checks++; if (wb_valid !== 1'b0 || wb_count !== cnt0) begin n_fail++; $display("FAIL stall_commit[%0d] got=%b/%0d want=0/%0d", k, wb_valid, wb_count, cnt0); end
    end
    stall = 0; #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got=%b want=1", bus.in_ready); end
    cycle();
    idle();
    n_checks++; if (wb_valid !== 1'b1 || wb_dest !== 2'd0 || rd_data_a !== 4'h6) begin n_fail++; $display("FAIL stall_first got=%b/%0d/%h want=1/0/6", wb_valid, wb_dest, rd_data_a); end
    cycle();
    n_checks++; if (wb_valid !== 1'b1 || wb_dest !== 2'd1 || rd_data_b !== 4'h9) begin n_fail++; $display("FAIL stall_second got=%b/%0d/%h want=1/1/9", wb_valid, wb_dest, rd_data_b); end
    n_checks++; if (flags !== 4'b0110 || wb_count !== 8'd2) begin n_fail++; $display("FAIL stall_state got=%b/%0d want=0110/2", flags, wb_count); end
    cycle();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got=%b want=0", wb_valid); end
  endtask

  task automatic test_bypass();
    do_reset();
    rd_addr_a = 2;
    send(4'h9, 2, 0, 0, 1, 0);
    cycle();
    idle();
    cycle();
    n_checks++; if (rd_data_a !== 4'h9) begin n_fail++; $display("FAIL bypass_base got=%h want=9", rd_data_a); end
    send(4'h5, 2, 0, 0, 1, 0);
    cycle();
    idle(); stall = 1; #1;
    n_checks++; if (rd_data_a !== 4'h9) begin n_fail++; $display("FAIL bypass_stalled got=%h want=9", rd_data_a); end
    stall = 0; #1;
    n_checks++; if (rd_data_a !== 4'h5) begin n_fail++; $display("FAIL bypass_same_cycle got=%h want=5", rd_data_a); end
    cycle();
    n_checks++; if (rd_data_a !== 4'h5 || flags !== 4'h0) begin n_fail++; $display("FAIL bypass_after got=%h/%b want=5/0000", rd_data_a, flags); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      send(W'($urandom), $urandom_range(0, N - 1), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      cycle();
    end
    idle();
    cycle();
    n_checks++; if (wb_count !== 8'd255) begin n_fail++; $display("FAIL saturate_count got=%0d want=255", wb_count); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    send(4'hF, 2, 1, 1, 1, 1);
    cycle();
    send(4'h7, 3, 0, 1, 1, 1);
    cycle();
    idle(); rst = 1;
    cycle();
    rst = 0;
    rd_addr_a = 3; rd_addr_b = 2; #1;
    n_checks++; if (rd_data_a !== 4'h0 || rd_data_b !== 4'h0) begin n_fail++; $display("FAIL rstfl_regs got=%h/%h want=0/0", rd_data_a, rd_data_b); end
    n_checks++; if (flags !== 4'h0 || sticky_v !== 1'b0) begin n_fail++; $display("FAIL rstfl_flags got=%b/%b want=0000/0", flags, sticky_v); end
    n_checks++; if (wb_valid !== 1'b0 || wb_dest !== '0 || wb_count !== 8'd0) begin n_fail++; $display("FAIL rstfl_wb got=%b/%0d/%0d want=0/0/0", wb_valid, wb_dest, wb_count); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstfl_ready got=%b want=1", bus.in_ready); end
    cycle();
    n_checks++; if (wb_valid !== 1'b0 || rd_data_a !== 4'h0 || wb_count !== 8'd0) begin n_fail++; $display("FAIL rstfl_discard got=%b/%h/%0d want=0/0/0", wb_valid, rd_data_a, wb_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 500; k++) begin
      rst        = ($urandom_range(0, 59) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      send(W'($urandom), $urandom_range(0, N - 1), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      bus.in_valid = ($urandom_range(0, 3) != 0);
      rd_addr_a = AW'($urandom); rd_addr_b = AW'($urandom);
      #1;
      n_checks++; if (bus.in_ready !== (!m_valid || !stall)) begin n_fail++; $display("FAIL rand_ready[%0d] got=%b want=%b", k, bus.in_ready, (!m_valid || !stall)); end
      n_checks++; if (rd_data_a !== exp_rd(int'(rd_addr_a)) || rd_data_b !== exp_rd(int'(rd_addr_b))) begin
        n_fail++; $display("FAIL rand_read[%0d] got=%h/%h want=%h/%h", k, rd_data_a, rd_data_b, exp_rd(int'(rd_addr_a)), exp_rd(int'(rd_addr_b)));
      end
      cycle();
      n_checks++; if (flags !== m_flags || sticky_v !== m_sticky) begin n_fail++; $display("FAIL rand_flags[%0d] got=%b/%b want=%b/%b", k, flags, sticky_v, m_flags, m_sticky); end
      n_checks++; if (wb_valid !== m_wbv || wb_dest !== AW'(m_wbd) || wb_count !== 8'(m_cnt)) begin
        n_fail++; $display("FAIL rand_wb[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", k, wb_valid, wb_dest, wb_count, m_wbv, m_wbd, m_cnt);
      end
    end
    rst = 0; stall = 0; clr_sticky = 0; idle();
  endtask

  initial begin
    rst = 1; stall = 0; clr_sticky = 0; rd_addr_a = '0; rd_addr_b = '0;
    bus.in_valid = 0; bus.in_result = '0; bus.in_carry = 0; bus.in_overflow = 0;
    bus.in_dest = '0; bus.in_wen = 0; bus.in_flag_en = 0;
    test_reset();
    test_zero_flags();
    test_sticky();
    test_stall();
    test_bypass();
    test_saturate();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog elapsed=%0t limit=2000000", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
